register_file: RTL and testbench
================================

Name: register_file

Overview:
- LEGv8 register file. It sits directly downstream of the Reg2Loc read-register-2 select mux.
- Read port 1 takes Rn from the instruction decoder. Read port 2 takes the mux output (Rm or Rt).
- Write port receives the writeback value. A third, read-only debug port serves the bench and trace.
- Holds the 32 architectural registers X0..X31. X31 is hard-wired XZR (reads zero, writes discarded).

Parameters:
- DATA_WIDTH, 64, width of each register and of every data port.
- ADDR_WIDTH, 5, register index width. Fixed at 5 for LEGv8; other values are unsupported.
- WRITE_THROUGH, 1. When 1, a read of the register being written this cycle returns Write_data. When 0, it returns the old contents.

Ports:
- clk  input  1  Single clock. All state updates on its rising edge.
- reset  input  1  Synchronous, active-high reset.
- Read_register1  input  5  Read index A (instruction bits [9:5], Rn).
- Read_register2  input  5  Read index B (Reg2Loc mux output).
- Write_register  input  5  Write index (instruction bits [4:0], Rd/Rt).
- Write_data  input  DATA_WIDTH  Writeback value.
- RegWrite  input  1  Write enable from control.
- Read_data1  output  DATA_WIDTH  Contents at Read_register1.
- Read_data2  output  DATA_WIDTH  Contents at Read_register2.
- Dbg_register  input  5  Debug read index.
- Dbg_data  output  DATA_WIDTH  Contents at Dbg_register. Never bypassed.
- Write_count  output  16  Number of committed writes since reset. Saturates at 16'hFFFF.

Behaviour:
- Storage: 31 flops X0..X30 of DATA_WIDTH. No storage exists for X31.
- Reset: synchronous, active-high.
  - While reset is high at a rising edge, X0..X30 <= 0 and Write_count <= 0.
  - Reset dominates RegWrite; a write requested in a reset cycle is dropped.
  - Reset may be asserted mid-program; the next edge clears all state regardless of any in-flight write.
- Write: at a rising edge with reset=0, RegWrite=1 and Write_register!=31:
  - register[Write_register] <= Write_data;
  - Write_count increments unless already 16'hFFFF.
  - A write to index 31 is discarded and does not increment Write_count.
  - RegWrite=0 leaves all registers unchanged.
- Reads are combinational, with zero-cycle latency from address to data.
  - Index 31 returns all zeros on every read port.
  - Outputs after reset: Read_data1, Read_data2 and Dbg_data are 0 for every index.
  - Write_count reads 0 after reset.
- Bypass (WRITE_THROUGH=1):
  - Condition: RegWrite=1, reset=0, Write_register!=31 and the read index equals Write_register.
  - When the condition holds, Read_data1/2 equal Write_data in the same cycle. Both ports may bypass at once.
  - Dbg_data always shows stored state only.
- WRITE_THROUGH=0: reads return the pre-edge contents. The new value is visible from the cycle after the edge.
- Unknown index: if any bit of a read index is X/Z, the matching read data is all X in simulation. This matches the decoder-mux default.
- Simultaneous events:
  - Same index on both read ports: both return identical data.
  - Read and write of the same index: governed by WRITE_THROUGH.
  - reset plus RegWrite: reset wins.
- No stalls and no handshake. One write per cycle at most.

Decomposition:
- Shared package legv8_pkg holds:
  - constants XZR_INDEX=5'd31, NUM_REGS=32, DATA_WIDTH=64;
  - typedef reg_idx_t (5-bit) and typedef xword_t (64-bit).
  - The decoder, the Reg2Loc mux and this block all reference these.
- One natural sub-module: regfile_read_port. It is instantiated three times (debug instance with bypass disabled). Each instance does:
  - index decode;
  - XZR zero-forcing;
  - X propagation;
  - optional bypass compare.

Test Plan:
- Reset then read all: pulse reset one cycle, sweep Read_register1/2 and Dbg_register over 0..31 -> all data 0, Write_count=0.
- Write/readback: write X5=64'hDEADBEEF_01234567 with RegWrite=1 -> after the edge, Read_data1 (idx 5) and Dbg_data (idx 5) equal that value; Write_count=1.
- XZR: RegWrite=1, Write_register=31, Write_data=64'hFFFF_FFFF_FFFF_FFFF -> all ports reading 31 return 0, before and after the edge; Write_count unchanged.
- Bypass: WRITE_THROUGH=1, X7=64'h1, same cycle write X7=64'h2 with Read_register2=7 -> Read_data2=64'h2 before the edge and Dbg_data=64'h1. Repeat with WRITE_THROUGH=0 -> Read_data2=64'h1 until the edge, then 64'h2.
- Reset vs write: fill X1..X30 with nonzero values, then assert reset with RegWrite=1, Write_register=3, Write_data=64'hAA -> the next cycle all registers read 0 and Write_count=0.
- Counter saturation: force 65540 writes to X0 -> Write_count holds 16'hFFFF and X0 holds the last value written.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions used by the decoder, the Reg2Loc mux and the register file.
package legv8_pkg;
  localparam logic [4:0] XZR_INDEX  = 5'd31;
  localparam int         NUM_REGS   = 32;
  localparam int         DATA_WIDTH = 64;

  typedef logic [4:0]            reg_idx_t;
  typedef logic [DATA_WIDTH-1:0] xword_t;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: decode, XZR forcing, X propagation and optional bypass.
module regfile_read_port
  import legv8_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter bit BYPASS     = 1'b1
) (
  input  logic [NUM_REGS-2:0][DATA_WIDTH-1:0] regs,
  input  reg_idx_t                            idx,
  input  logic                                wr_commit,
  input  reg_idx_t                            wr_idx,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  output logic [DATA_WIDTH-1:0]               data
);
  logic [NUM_REGS-2:0]                 sel;
  logic [NUM_REGS-2:0][DATA_WIDTH-1:0] masked;

  // Index 31 never matches a slot, so XZR falls out of the OR tree as zero.
  generate
    for (genvar gi = 0; gi < NUM_REGS - 1; gi++) begin : g_decode
      assign sel[gi]    = (idx == reg_idx_t'(gi));
      assign masked[gi] = regs[gi] & {DATA_WIDTH{sel[gi]}};
    end
  endgenerate

  always_comb begin
    data = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      data = data | masked[i];
    end
    if (BYPASS && wr_commit && (idx == wr_idx)) begin
      data = wr_data;
    end
    // An unknown index yields unknown data in simulation; constant-false in hardware.
    if ((^idx) === 1'bx) begin
      data = 'x;
    end
  end
endmodule

// File: rtl/register_file.sv
// LEGv8 register file: 31 storage registers plus hard-wired XZR, two read ports, one debug port.
module register_file
  import legv8_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 5,
  parameter bit WRITE_THROUGH = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] Read_register1,
  input  logic [ADDR_WIDTH-1:0] Read_register2,
  input  logic [ADDR_WIDTH-1:0] Write_register,
  input  logic [DATA_WIDTH-1:0] Write_data,
  input  logic                  RegWrite,
  output logic [DATA_WIDTH-1:0] Read_data1,
  output logic [DATA_WIDTH-1:0] Read_data2,
  input  logic [ADDR_WIDTH-1:0] Dbg_register,
  output logic [DATA_WIDTH-1:0] Dbg_data,
  output logic [15:0]           Write_count
);
  logic [NUM_REGS-2:0][DATA_WIDTH-1:0] regs_reg;
  logic [15:0]                         count_reg;
  logic                                commit;

  // A write only lands when not in reset and not aimed at XZR.
  assign commit = RegWrite && !reset && (Write_register != XZR_INDEX);

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_reg  <= '0;
      count_reg <= '0;
    end else if (commit) begin
      regs_reg[Write_register] <= Write_data;
      if (count_reg != 16'hFFFF) begin
        count_reg <= count_reg + 16'd1;
      end
    end
  end

  assign Write_count = count_reg;

  regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .BYPASS(WRITE_THROUGH)) u_port1 (
    .regs      (regs_reg),
    .idx       (Read_register1),
    .wr_commit (commit),
    .wr_idx    (Write_register),
    .wr_data   (Write_data),
    .data      (Read_data1)
  );

  regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .BYPASS(WRITE_THROUGH)) u_port2 (
    .regs      (regs_reg),
    .idx       (Read_register2),
    .wr_commit (commit),
    .wr_idx    (Write_register),
    .wr_data   (Write_data),
    .data      (Read_data2)
  );

  // The debug view always reflects stored state only.
  regfile_read_port #(.DATA_WIDTH(DATA_WIDTH), .BYPASS(1'b0)) u_port_dbg (
    .regs      (regs_reg),
    .idx       (Dbg_register),
    .wr_commit (commit),
    .wr_idx    (Write_register),
    .wr_data   (Write_data),
    .data      (Dbg_data)
  );
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench: directed table, hand sequences and randomized traffic against an array model.
module tb_register_file;
  logic        clk;
  logic        reset;
  logic [4:0]  rr1, rr2, wr, dbg;
  logic [63:0] wdata;
  logic        we;
  logic [63:0] rd1, rd2, dbgd, rd1_nb, rd2_nb, dbgd_nb;
  logic [15:0] wcnt, wcnt_nb;

  int checks   = 0;
  int failures = 0;

  register_file #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .WRITE_THROUGH(1'b1)) dut (
    .clk(clk), .reset(reset), .Read_register1(rr1), .Read_register2(rr2),
    .Write_register(wr), .Write_data(wdata), .RegWrite(we),
    .Read_data1(rd1), .Read_data2(rd2), .Dbg_register(dbg), .Dbg_data(dbgd),
    .Write_count(wcnt)
  );

  register_file #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .WRITE_THROUGH(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .Read_register1(rr1), .Read_register2(rr2),
    .Write_register(wr), .Write_data(wdata), .RegWrite(we),
    .Read_data1(rd1_nb), .Read_data2(rd2_nb), .Dbg_register(dbg), .Dbg_data(dbgd_nb),
    .Write_count(wcnt_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  widx;
    logic [63:0] wdata;
    logic [4:0]  r1, r2, dbg;
    logic [63:0] e_rd1, e_rd2, e_dbg;     // write-through instance
    logic [63:0] e_rd1_nb, e_rd2_nb;      // non-bypassing instance
    logic [15:0] e_cnt;
  } vec_t;

  localparam logic [63:0] V5 = 64'hDEADBEEF_01234567;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  vec_t vecs [7];

  // Reference model: architectural contents and commit counter.
  logic [63:0] model [32];
  int          model_cnt;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = '0;
    model_cnt = 0;
  endtask

  // Drive inputs on the falling edge so they settle well before the rising edge.
  task automatic drive(input logic rst, input logic w, input logic [4:0] wi, input logic [63:0] wd,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    @(negedge clk);
    reset = rst; we = w; wr = wi; wdata = wd; rr1 = a; rr2 = b; dbg = d;
    #1;
  endtask

  task automatic pulse_reset();
    drive(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
    model_reset();
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; wr = '0; wdata = '0; rr1 = '0; rr2 = '0; dbg = '0;
    model_reset();

    // Reset, then sweep every index on every port.
    pulse_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i), 5'(i));
      check($sformatf("reset_rd1[%0d]", i), rd1, 64'd0);
      check($sformatf("reset_rd2[%0d]", 31 - i), rd2, 64'd0);
      check($sformatf("reset_dbg[%0d]", i), dbgd, 64'd0);
    end
    check("reset_count", {48'd0, wcnt}, 64'd0);

    // Directed table: expected values are those seen just before each rising edge.
    vecs[0] = '{1'b1, 5'd5,  V5,     5'd5,  5'd0,  5'd5,  V5,    64'd0, 64'd0, 64'd0, 64'd0, 16'd0};
    vecs[1] = '{1'b0, 5'd0,  64'd0,  5'd5,  5'd5,  5'd5,  V5,    V5,    V5,    V5,    V5,    16'd1};
    vecs[2] = '{1'b1, 5'd31, ONES,   5'd31, 5'd31, 5'd31, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 16'd1};
    vecs[3] = '{1'b0, 5'd0,  64'd0,  5'd31, 5'd31, 5'd31, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 16'd1};
    vecs[4] = '{1'b1, 5'd7,  64'h1,  5'd0,  5'd7,  5'd7,  64'd0, 64'h1, 64'd0, 64'd0, 64'd0, 16'd1};
    vecs[5] = '{1'b1, 5'd7,  64'h2,  5'd7,  5'd7,  5'd7,  64'h2, 64'h2, 64'h1, 64'h1, 64'h1, 16'd2};
    vecs[6] = '{1'b0, 5'd0,  64'd0,  5'd7,  5'd7,  5'd7,  64'h2, 64'h2, 64'h2, 64'h2, 64'h2, 16'd3};
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, vecs[i].we, vecs[i].widx, vecs[i].wdata, vecs[i].r1, vecs[i].r2, vecs[i].dbg);
      check($sformatf("vec%0d_rd1", i), rd1, vecs[i].e_rd1);
      check($sformatf("vec%0d_rd2", i), rd2, vecs[i].e_rd2);
      check($sformatf("vec%0d_dbg", i), dbgd, vecs[i].e_dbg);
      check($sformatf("vec%0d_rd1_nb", i), rd1_nb, vecs[i].e_rd1_nb);
      check($sformatf("vec%0d_rd2_nb", i), rd2_nb, vecs[i].e_rd2_nb);
      check($sformatf("vec%0d_cnt", i), {48'd0, wcnt}, {48'd0, vecs[i].e_cnt});
      check($sformatf("vec%0d_cnt_nb", i), {48'd0, wcnt_nb}, {48'd0, vecs[i].e_cnt});
    end

    // Reset beats a simultaneous write after X1..X30 are populated.
    for (int i = 1; i < 31; i++)
      drive(1'b0, 1'b1, 5'(i), 64'h0101_0101_0101_0101 * 64'(i), 5'd0, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd30, 5'd1, 5'd15);
    check("fill_rd1_x30", rd1, 64'h0101_0101_0101_0101 * 64'd30);
    check("fill_dbg_x15", dbgd, 64'h0101_0101_0101_0101 * 64'd15);
    drive(1'b1, 1'b1, 5'd3, 64'hAA, 5'd3, 5'd3, 5'd3);
    model_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(i), 5'(i));
      check($sformatf("rstwr_rd1[%0d]", i), rd1, 64'd0);
      check($sformatf("rstwr_rd2[%0d]", i), rd2, 64'd0);
      check($sformatf("rstwr_dbg[%0d]", i), dbgd, 64'd0);
    end
    check("rstwr_count", {48'd0, wcnt}, 64'd0);

    // Randomized traffic against the reference model, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      logic        r_rst, r_we;
      logic [4:0]  r_wi, r_a, r_b, r_d;
      logic [63:0] r_wd, exp_a, exp_b;
      r_rst = ($urandom_range(0, 49) == 0);
      r_we  = $urandom_range(0, 2) != 0;
      r_wi  = 5'($urandom_range(0, 31));
      r_wd  = {$urandom, $urandom};
      r_a   = ($urandom_range(0, 3) == 0) ? r_wi : 5'($urandom_range(0, 31));
      r_b   = ($urandom_range(0, 3) == 0) ? r_wi : 5'($urandom_range(0, 31));
      r_d   = ($urandom_range(0, 3) == 0) ? r_wi : 5'($urandom_range(0, 31));
      drive(r_rst, r_we, r_wi, r_wd, r_a, r_b, r_d);
      exp_a = (!r_rst && r_we && r_wi != 5'd31 && r_wi == r_a) ? r_wd : model[r_a];
      exp_b = (!r_rst && r_we && r_wi != 5'd31 && r_wi == r_b) ? r_wd : model[r_b];
      check("rand_rd1", rd1, exp_a);
      check("rand_rd2", rd2, exp_b);
      check("rand_dbg", dbgd, model[r_d]);
      check("rand_rd1_nb", rd1_nb, model[r_a]);
      check("rand_rd2_nb", rd2_nb, model[r_b]);
      check("rand_cnt", {48'd0, wcnt}, 64'(model_cnt));
      if (r_rst) model_reset();
      else if (r_we && r_wi != 5'd31) begin
        model[r_wi] = r_wd;
        if (model_cnt < 65535) model_cnt++;
      end
    end

    // Counter saturation: 65540 writes to X0.
    pulse_reset();
    for (int i = 0; i < 65540; i++) begin
      drive(1'b0, 1'b1, 5'd0, 64'(i), 5'd0, 5'd0, 5'd0);
      if (i == 65534) check("sat_cnt_before_last", {48'd0, wcnt}, 64'hFFFE);
    end
    drive(1'b0, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
    check("sat_cnt", {48'd0, wcnt}, 64'hFFFF);
    check("sat_cnt_nb", {48'd0, wcnt_nb}, 64'hFFFF);
    check("sat_x0", dbgd, 64'd65539);
    check("sat_x0_rd1", rd1, 64'd65539);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
